ofm_writeback_scheduler: RTL and testbench

//  Sequences axi_master_ofm for one layer's OFM writeback. Accepts tile-complete events from the

---
 rtl/ofm_writeback_scheduler.sv | 247 ++++++++++++++++++++++++
 tb/tb_ofm_writeback_scheduler.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofm_writeback_scheduler.sv
// OFM writeback sequencer: queues finished ping-pong tiles and issues one write-master burst per stride.
// Optional build macro OFM_WB_PERF_EN adds saturating wait/idle cycle counters.
module ofm_writeback_scheduler #(
  parameter int unsigned AXI_ADDR_W = 32,
  parameter int unsigned AXI_DATA_W = 128,
  parameter int unsigned BURST_LEN  = 128,
  parameter int unsigned TILE_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  layer_start,
  input  logic [AXI_ADDR_W-1:0] cfg_ofm_base,
  input  logic [TILE_CNT_W-1:0] cfg_num_tiles,
  input  logic [7:0]            cfg_bursts_per_tile,
  input  logic                  tile_ready,
  input  logic                  tile_buf,
  output logic [1:0]            buf_busy,
  output logic                  start_write,
  output logic [AXI_ADDR_W-1:0] base_addr,
  output logic                  buf_sel,
  input  logic                  wr_done,
  output logic                  busy,
  output logic                  layer_done,
  output logic                  err_overrun
`ifdef OFM_WB_PERF_EN
  ,
  output logic [31:0]           perf_wait_cycles,
  output logic [31:0]           perf_idle_cycles
`endif
);

  localparam int unsigned BSTRIDE = BURST_LEN * AXI_DATA_W / 8;
  localparam int unsigned ALIGN_W = $clog2(BSTRIDE);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TILE = 3'd1,
    ISSUE     = 3'd2,
    WAIT_DONE = 3'd3,
    NEXT      = 3'd4
  } state_t;

  state_t                state;
  state_t                state_next;

  logic [TILE_CNT_W-1:0] num_tiles;
  logic [7:0]            bpt;
  logic [7:0]            burst_cnt;
  logic [TILE_CNT_W-1:0] tile_cnt;
  logic [TILE_CNT_W-1:0] push_cnt;

  // Two-entry shift FIFO of buffer indices; q_head drives the read mux directly.
  logic                  q_head;
  logic                  q_tail;
  logic [1:0]            q_cnt;

  logic                  latch;
  logic                  burst_last;
  logic                  tile_last;
  logic                  rel;
  logic [1:0]            rel_mask;
  logic [1:0]            busy_after_rel;
  logic                  push;
  logic [1:0]            push_mask;
  logic                  overrun;
  logic [1:0]            q_cnt_pop;
  logic                  q_head_n;
  logic                  q_tail_n;
  logic [1:0]            q_cnt_n;
  logic                  start_write_d;
  logic                  busy_d;
  logic                  layer_done_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (layer_start && (cfg_num_tiles != '0)) begin
          state_next = WAIT_TILE;
        end
      end
      WAIT_TILE: begin
        if (q_cnt != 2'd0) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (wr_done) begin
          state_next = NEXT;
        end
      end
      NEXT: begin
        if (!burst_last) begin
          state_next = ISSUE;
        end else if (tile_last) begin
          state_next = IDLE;
        end else begin
          state_next = WAIT_TILE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Control and output-next logic; a release in NEXT is applied before a same-edge push
  always_comb begin
    latch          = 1'b0;
    burst_last     = 1'b0;
    tile_last      = 1'b0;
    rel            = 1'b0;
    rel_mask       = 2'b00;
    busy_after_rel = buf_busy;
    push           = 1'b0;
    push_mask      = 2'b00;
    overrun        = 1'b0;
    q_cnt_pop      = q_cnt;
    q_head_n       = q_head;
    q_tail_n       = q_tail;
    q_cnt_n        = q_cnt;
    start_write_d  = 1'b0;
    busy_d         = 1'b0;
    layer_done_d   = 1'b0;

    latch          = (state == IDLE) && layer_start;
    burst_last     = (8'(burst_cnt + 8'd1) >= bpt);
    tile_last      = (TILE_CNT_W'(tile_cnt + 1'b1) == num_tiles);
    rel            = (state == NEXT) && burst_last;
    rel_mask       = rel ? 2'(2'b01 << q_head) : 2'b00;
    busy_after_rel = buf_busy & ~rel_mask;

    push      = tile_ready && (state != IDLE) && (push_cnt < num_tiles) &&
                !busy_after_rel[tile_buf];
    push_mask = push ? 2'(2'b01 << tile_buf) : 2'b00;
    overrun   = tile_ready && !push;

    q_cnt_pop = rel ? 2'(q_cnt - 2'd1) : q_cnt;
    q_head_n  = rel ? q_tail : q_head;
    if (push) begin
      if (q_cnt_pop == 2'd0) begin
        q_head_n = tile_buf;
      end else begin
        q_tail_n = tile_buf;
      end
    end
    q_cnt_n = 2'(q_cnt_pop + {1'b0, push});

    start_write_d = (state_next == ISSUE);
    busy_d        = (state_next != IDLE);
    layer_done_d  = (latch && (cfg_num_tiles == '0)) || (rel && tile_last);
  end

  // Registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_write <= 1'b0;
      busy        <= 1'b0;
      layer_done  <= 1'b0;
    end else begin
      start_write <= start_write_d;
      busy        <= busy_d;
      layer_done  <= layer_done_d;
    end
  end

  // Layer configuration and progress counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_tiles <= '0;
      bpt       <= 8'd0;
      burst_cnt <= 8'd0;
      tile_cnt  <= '0;
      push_cnt  <= '0;
      base_addr <= '0;
    end else if (latch) begin
      num_tiles <= cfg_num_tiles;
      bpt       <= (cfg_bursts_per_tile == 8'd0) ? 8'd1 : cfg_bursts_per_tile;
      burst_cnt <= 8'd0;
      tile_cnt  <= '0;
      push_cnt  <= '0;
      base_addr <= {cfg_ofm_base[AXI_ADDR_W-1:ALIGN_W], {ALIGN_W{1'b0}}};
    end else begin
      if (state == NEXT) begin
        base_addr <= AXI_ADDR_W'(base_addr + AXI_ADDR_W'(BSTRIDE));
        burst_cnt <= burst_last ? 8'd0 : 8'(burst_cnt + 8'd1);
      end
      if (rel) begin
        tile_cnt <= TILE_CNT_W'(tile_cnt + 1'b1);
      end
      if (push) begin
        push_cnt <= TILE_CNT_W'(push_cnt + 1'b1);
      end
    end
  end

  // Buffer ownership, tile queue and sticky overrun flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_busy    <= 2'b00;
      q_head      <= 1'b0;
      q_tail      <= 1'b0;
      q_cnt       <= 2'd0;
      buf_sel     <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      buf_busy    <= busy_after_rel | push_mask;
      q_head      <= q_head_n;
      q_tail      <= q_tail_n;
      q_cnt       <= latch ? 2'd0 : q_cnt_n;
      buf_sel     <= q_head_n;
      err_overrun <= latch ? overrun : (err_overrun | overrun);
    end
  end

`ifdef OFM_WB_PERF_EN
  // Saturating stall counters, restarted per layer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_wait_cycles <= 32'd0;
      perf_idle_cycles <= 32'd0;
    end else if (latch) begin
      perf_wait_cycles <= 32'd0;
      perf_idle_cycles <= 32'd0;
    end else begin
      if ((state == WAIT_DONE) && (perf_wait_cycles != 32'hFFFF_FFFF)) begin
        perf_wait_cycles <= perf_wait_cycles + 32'd1;
      end
      if ((state == WAIT_TILE) && (perf_idle_cycles != 32'hFFFF_FFFF)) begin
        perf_idle_cycles <= perf_idle_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ofm_writeback_scheduler.sv
// Scoreboard bench for ofm_writeback_scheduler: random tiles, write-master responses and
// misuse, checked against a queue-based model of bursts, buffer ownership and overrun.
module tb_ofm_writeback_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        layer_start = 1'b0;
  logic [31:0] cfg_ofm_base = 32'd0;
  logic [15:0] cfg_num_tiles = 16'd0;
  logic [7:0]  cfg_bursts_per_tile = 8'd0;
  logic        tile_ready = 1'b0;
  logic        tile_buf = 1'b0;
  logic [1:0]  buf_busy;
  logic        start_write;
  logic [31:0] base_addr;
  logic        buf_sel;
  logic        wr_done = 1'b0;
  logic        busy;
  logic        layer_done;
  logic        err_overrun;
`ifdef OFM_WB_PERF_EN
  logic [31:0] perf_wait_cycles;
  logic [31:0] perf_idle_cycles;
`endif

  always #5 clk = ~clk;

  ofm_writeback_scheduler dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .layer_start         (layer_start),
    .cfg_ofm_base        (cfg_ofm_base),
    .cfg_num_tiles       (cfg_num_tiles),
    .cfg_bursts_per_tile (cfg_bursts_per_tile),
    .tile_ready          (tile_ready),
    .tile_buf            (tile_buf),
    .buf_busy            (buf_busy),
    .start_write         (start_write),
    .base_addr           (base_addr),
    .buf_sel             (buf_sel),
    .wr_done             (wr_done),
    .busy                (busy),
    .layer_done          (layer_done),
    .err_overrun         (err_overrun)
`ifdef OFM_WB_PERF_EN
    ,
    .perf_wait_cycles    (perf_wait_cycles),
    .perf_idle_cycles    (perf_idle_cycles)
`endif
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        b;
  } exp_t;

  exp_t exp_q[$];
  int   m_q[$];
  bit   m_busy[2];
  bit   m_err;
  int   n_tests = 0;
  int   n_fail = 0;
  int   ld_count = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every start_write must match the oldest expected burst
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      if (start_write) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_start_write: addr 0x%08h buf %0d, no burst expected", base_addr, buf_sel);
        end else begin
          e = exp_q.pop_front();
          check("burst_addr", 64'(base_addr), 64'(e.addr));
          check("burst_buf", 64'(buf_sel), 64'(e.b));
        end
      end
      if (layer_done) ld_count++;
    end
  end

  task automatic run_layer(input logic [31:0] base, input int num, input int bpt_raw);
    int          ld0, cnt, bpt, acc, done_tiles, burst, b;
    logic [31:0] abase;
    bit          rel_pend, finishing, finished, offer;
    exp_t        e;
    ld0 = ld_count; cnt = 0; acc = 0; done_tiles = 0; burst = 0;
    rel_pend = 0; finishing = 0; finished = 0;
    bpt   = (bpt_raw == 0) ? 1 : bpt_raw;
    abase = base & 32'hFFFF_F800;
    layer_start = 1'b1;
    cfg_ofm_base = base;
    cfg_num_tiles = 16'(num);
    cfg_bursts_per_tile = 8'(bpt_raw);
    @(negedge clk);
    layer_start = 1'b0;
    m_err = 1'b0;
    check("err_cleared_on_start", 64'(err_overrun), 64'd0);
    if (num == 0) begin
      check("zero_tiles_done", 64'(layer_done), 64'd1);
      check("zero_tiles_busy", 64'(busy), 64'd0);
      finished = 1;
    end else begin
      check("busy_on_start", 64'(busy), 64'd1);
      for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
        check("buf_busy", 64'(buf_busy), 64'({m_busy[1], m_busy[0]}));
        check("err_overrun", 64'(err_overrun), 64'(m_err));
        if (finishing) begin
          check("layer_done", 64'(layer_done), 64'd1);
          check("busy_after_layer", 64'(busy), 64'd0);
          finished = 1;
        end else begin
          tile_ready = 1'b0;
          wr_done = 1'b0;
          layer_start = 1'b0;
          // Buffer whose last burst completed last cycle is released on this edge
          if (rel_pend) begin
            m_busy[m_q.pop_front()] = 1'b0;
            done_tiles++;
            burst = 0;
            rel_pend = 0;
            if (done_tiles == num) finishing = 1;
          end
          if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
              wr_done = 1'b1;
              burst++;
              if (burst == bpt) rel_pend = 1;
            end
          end else if (!start_write && $urandom_range(0, 7) == 0) begin
            wr_done = 1'b1;
          end
          if (start_write) cnt = $urandom_range(1, 5);
          offer = (acc < num) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 29) == 0);
          if (offer) begin
            if (!m_busy[0] && !m_busy[1]) b = $urandom_range(0, 1);
            else if (!m_busy[0] && $urandom_range(0, 4) != 0) b = 0;
            else if (!m_busy[1] && $urandom_range(0, 4) != 0) b = 1;
            else b = $urandom_range(0, 1);
            tile_ready = 1'b1;
            tile_buf = 1'(b);
            if (!m_busy[b] && acc < num) begin
              m_busy[b] = 1'b1;
              m_q.push_back(b);
              for (int j = 0; j < bpt; j++) begin
                e.addr = abase + 32'((acc * bpt + j) * 2048);
                e.b = 1'(b);
                exp_q.push_back(e);
              end
              acc++;
            end else begin
              m_err = 1'b1;
            end
          end
          if (!finishing && $urandom_range(0, 39) == 0) begin
            layer_start = 1'b1;
            cfg_ofm_base = $urandom;
            cfg_num_tiles = 16'($urandom_range(0, 3));
            cfg_bursts_per_tile = 8'($urandom_range(0, 3));
          end
          @(negedge clk);
        end
      end
      if (!finished) begin
        n_tests++;
        n_fail++;
        $display("FAIL layer_timeout: layer_done not seen, %0d of %0d tiles done", done_tiles, num);
      end
    end
    tile_ready = 1'b0;
    wr_done = 1'b0;
    layer_start = 1'b0;
    @(negedge clk);
    check("layer_done_pulses", 64'(ld_count - ld0), 64'd1);
    check("bursts_outstanding", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic idle_gap();
    for (int i = 0; i < 4; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        tile_ready = 1'b1;
        tile_buf = 1'($urandom_range(0, 1));
        m_err = 1'b1;
      end else begin
        tile_ready = 1'b0;
      end
      @(negedge clk);
    end
    tile_ready = 1'b0;
    @(negedge clk);
    check("err_overrun_idle", 64'(err_overrun), 64'(m_err));
    check("busy_idle", 64'(busy), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_buf_busy"}, 64'(buf_busy), 64'd0);
    check({tag, "_start_write"}, 64'(start_write), 64'd0);
    check({tag, "_base_addr"}, 64'(base_addr), 64'd0);
    check({tag, "_buf_sel"}, 64'(buf_sel), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_layer_done"}, 64'(layer_done), 64'd0);
    check({tag, "_err"}, 64'(err_overrun), 64'd0);
  endtask

  initial begin : driver
    exp_t e;
    m_busy[0] = 1'b0;
    m_busy[1] = 1'b0;
    m_err = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_layer(32'h1000_0000, 1, 1);
    idle_gap();
    run_layer(32'h0000_0000, 3, 2);
    run_layer(32'h1234_5678, 2, 1);
    run_layer(32'hFFFF_F000, 3, 3);
    run_layer(32'h0000_0055, 0, 4);
    idle_gap();
    for (int i = 0; i < 25; i++) begin
      run_layer($urandom, $urandom_range(1, 5), $urandom_range(0, 3));
      idle_gap();
    end

    // Start-write latency, then reset in the middle of the burst
    m_err = 1'b0;
    layer_start = 1'b1;
    cfg_ofm_base = 32'h0ABC_D123;
    cfg_num_tiles = 16'd2;
    cfg_bursts_per_tile = 8'd1;
    @(negedge clk);
    layer_start = 1'b0;
    tile_ready = 1'b1;
    tile_buf = 1'b1;
    e.addr = 32'h0ABC_D000;
    e.b = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    tile_ready = 1'b0;
    check("latency_cycle1", 64'(start_write), 64'd0);
    @(negedge clk);
    check("latency_cycle2", 64'(start_write), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("midburst_reset");
    @(negedge clk);
    rst_n = 1'b1;
    m_busy[0] = 1'b0;
    m_busy[1] = 1'b0;
    m_q.delete();
    exp_q.delete();
    @(negedge clk);
    check("post_reset_busy", 64'(busy), 64'd0);
    run_layer(32'h2000_0000, 2, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
